// File: rtl/nec_prefetch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nec_prefetch_pkg : shared types and helpers for the prefetch unit     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package nec_prefetch_pkg;

    localparam int IPQ_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } prefetch_state_e;

    // Real-mode style segment:offset translation, wrapping at 1 MiB.
    function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] ofs);
        return {seg, 4'b0000} + {4'b0000, ofs};
    endfunction

endpackage
`default_nettype wire

// File: rtl/nec_prefetch_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nec_prefetch_if : code-fetch bus between prefetch unit and memory     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface nec_prefetch_if;
    logic        bus_req;
    logic [19:0] bus_addr;
    logic        bus_byte;
    logic        bus_ack;
    logic        bus_rvalid;
    logic [15:0] bus_rdata;

    modport master (
        output bus_req, bus_addr, bus_byte,
        input  bus_ack, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_addr, bus_byte,
        output bus_ack, bus_rvalid, bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/nec_prefetch_sva.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nec_prefetch_sva : queue-window and request-stability invariants      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module nec_prefetch_sva (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        set_pc,
    input  logic [15:0] fetch_ip,
    input  logic [15:0] pc,
    input  logic        bus_req,
    input  logic [19:0] bus_addr,
    input  logic        bus_ack
);
    logic [15:0] window;
    assign window = fetch_ip - pc;

    a_window: assert property (@(posedge clk) disable iff (!reset_n)
        !set_pc |-> (window <= 16'd8));

    // An unaccepted request must not move or vanish unless redirected.
    a_req_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (bus_req && !(en && (bus_ack || set_pc))) |=> (bus_req && $stable(bus_addr)));
endmodule
`default_nettype wire

// File: rtl/nec_prefetch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nec_prefetch : 8-byte instruction prefetch queue on a 16-bit bus      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module nec_prefetch
    import nec_prefetch_pkg::*;
#(
    parameter int          QUEUE_BYTES = IPQ_BYTES,
    parameter logic [15:0] RESET_IP    = 16'h0000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         ce_1,
    input  logic                         ce_2,
    input  logic [15:0]                  cs,
    input  logic [15:0]                  pc,
    input  logic [15:0]                  new_pc,
    input  logic                         set_pc,
    input  logic                         block_prefetch,
    output logic [QUEUE_BYTES-1:0][7:0]  ipq,
    output logic [3:0]                   ipq_len,
    nec_prefetch_if.master               bus
);
    prefetch_state_e state;
    logic [15:0]     fetch_ip;
    logic            en;
    logic [3:0]      free;
    logic            can_issue;
    logic [2:0]      slot;

    assign en        = ce_1 | ce_2;
    assign ipq_len   = set_pc ? 4'd0 : (fetch_ip[3:0] - pc[3:0]);
    assign free      = 4'd8 - ipq_len;
    // Odd addresses fetch one byte to realign, so they need only one free slot.
    assign can_issue = !block_prefetch && !set_pc &&
                       (free >= (fetch_ip[0] ? 4'd1 : 4'd2));
    assign slot      = fetch_ip[2:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            fetch_ip      <= RESET_IP;
            ipq           <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_byte  <= 1'b0;
        end else if (en) begin
            if (set_pc) begin
                fetch_ip    <= new_pc;
                bus.bus_req <= 1'b0;
                case (state)
                    REQ:     state <= bus.bus_ack ? DISCARD : IDLE;
                    WAIT:    state <= DISCARD;
                    default: state <= state;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (can_issue) begin
                            state        <= REQ;
                            bus.bus_req  <= 1'b1;
                            bus.bus_addr <= phys_addr(cs, fetch_ip);
                            bus.bus_byte <= fetch_ip[0];
                        end
                    end
                    REQ: begin
                        if (bus.bus_ack) begin
                            bus.bus_req <= 1'b0;
                            state       <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.bus_rvalid) begin
                            if (bus.bus_byte) begin
                                ipq[slot] <= bus.bus_rdata[15:8];
                                fetch_ip  <= fetch_ip + 16'd1;
                            end else begin
                                ipq[slot]        <= bus.bus_rdata[7:0];
                                ipq[slot + 3'd1] <= bus.bus_rdata[15:8];
                                fetch_ip         <= fetch_ip + 16'd2;
                            end
                            state <= IDLE;
                        end
                    end
                    DISCARD: begin
                        if (bus.bus_rvalid) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    nec_prefetch_sva u_sva (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .set_pc   (set_pc),
        .fetch_ip (fetch_ip),
        .pc       (pc),
        .bus_req  (bus.bus_req),
        .bus_addr (bus.bus_addr),
        .bus_ack  (bus.bus_ack)
    );
endmodule
`default_nettype wire

// File: tb/tb_nec_prefetch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_nec_prefetch : directed self-checking bench for nec_prefetch       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_nec_prefetch;
    logic             clk = 1'b0;
    logic             reset_n, ce_1, ce_2, set_pc, block_prefetch;
    logic [15:0]      cs, pc, new_pc;
    logic [7:0][7:0]  ipq;
    logic [3:0]       ipq_len;

    nec_prefetch_if bus();

    nec_prefetch #(.QUEUE_BYTES(8), .RESET_IP(16'h0000)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ce_1           (ce_1),
        .ce_2           (ce_2),
        .cs             (cs),
        .pc             (pc),
        .new_pc         (new_pc),
        .set_pc         (set_pc),
        .block_prefetch (block_prefetch),
        .ipq            (ipq),
        .ipq_len        (ipq_len),
        .bus            (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] seg;
        logic [15:0] ip;
        logic [19:0] addr;
        logic        bsel;
    } vec_t;

    vec_t        vecs [5];
    logic [7:0]  m_q [8];
    logic [15:0] m_ip;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [63:0] m_pack();
        logic [63:0] p;
        for (int i = 0; i < 8; i++) p[i*8 +: 8] = m_q[i];
        return p;
    endfunction

    function automatic logic [3:0] m_len();
        logic [15:0] d;
        d = m_ip - pc;
        return d[3:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic redirect(input logic [15:0] a);
        set_pc = 1'b1; new_pc = a; pc = a; m_ip = a;
        step();
        set_pc = 1'b0;
    endtask

    // One bus transaction; expected address and size come from the model.
    task automatic serve(input logic [15:0] d, input int waits);
        int          n;
        logic [2:0]  s;
        logic [19:0] ea;
        n  = 0;
        ea = {cs, 4'b0000} + {4'b0000, m_ip};
        while (bus.bus_req !== 1'b1 && n < 20) begin step(); n++; end
        chk("req_issued", bus.bus_req, 1);
        chk("req_addr", bus.bus_addr, ea);
        chk("req_byte", bus.bus_byte, m_ip[0]);
        bus.bus_ack = 1'b1; step(); bus.bus_ack = 1'b0;
        chk("req_dropped_on_ack", bus.bus_req, 0);
        repeat (waits) step();
        bus.bus_rdata = d; bus.bus_rvalid = 1'b1; step(); bus.bus_rvalid = 1'b0;
        s = m_ip[2:0];
        if (m_ip[0]) begin
            m_q[s] = d[15:8]; m_ip = m_ip + 16'd1;
        end else begin
            m_q[s] = d[7:0]; m_q[s + 3'd1] = d[15:8]; m_ip = m_ip + 16'd2;
        end
        chk("ipq_after_return", ipq, m_pack());
        chk("len_after_return", ipq_len, m_len());
    endtask

    initial begin
        vecs[0] = '{16'hF000, 16'h0100, 20'hF0100, 1'b0};
        vecs[1] = '{16'hF000, 16'h0003, 20'hF0003, 1'b1};
        vecs[2] = '{16'h1234, 16'hFFFF, 20'h2233F, 1'b1};
        vecs[3] = '{16'hFFFF, 16'h0010, 20'h00000, 1'b0};
        vecs[4] = '{16'h0800, 16'h8000, 20'h10000, 1'b0};
        for (int i = 0; i < 8; i++) m_q[i] = 8'h00;
        m_ip = 16'h0000;

        reset_n = 1'b0; ce_1 = 1'b1; ce_2 = 1'b0; set_pc = 1'b0; block_prefetch = 1'b1;
        cs = 16'hF000; pc = 16'h0000; new_pc = 16'h0000;
        bus.bus_ack = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = 16'h0000;
        #12;
        chk("rst_req", bus.bus_req, 0);
        chk("rst_addr", bus.bus_addr, 0);
        chk("rst_byte", bus.bus_byte, 0);
        chk("rst_ipq", ipq, 0);
        chk("rst_len", ipq_len, 0);
        step(); reset_n = 1'b1;
        step(); step();
        chk("block_idle_no_req", bus.bus_req, 0);

        // First-request address/size for a set of redirects.
        block_prefetch = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cs = vecs[i].seg;
            redirect(vecs[i].ip);
            chk("setpc_drops_req", bus.bus_req, 0);
            step();
            chk("vec_len", ipq_len, 0);
            chk("vec_req", bus.bus_req, 1);
            chk("vec_addr", bus.bus_addr, vecs[i].addr);
            chk("vec_byte", bus.bus_byte, vecs[i].bsel);
        end

        // Redirect coinciding with acceptance: data must be dropped.
        cs = 16'hF000;
        set_pc = 1'b1; new_pc = 16'h0400; pc = 16'h0400; m_ip = 16'h0400; bus.bus_ack = 1'b1;
        step();
        set_pc = 1'b0; bus.bus_ack = 1'b0;
        step(); step();
        chk("discard_no_req", bus.bus_req, 0);
        bus.bus_rdata = 16'h1234; bus.bus_rvalid = 1'b1; step(); bus.bus_rvalid = 1'b0;
        block_prefetch = 1'b1;
        chk("discard_no_write", ipq, m_pack());
        chk("discard_len", ipq_len, 0);

        // Sequential fill from 0x0100.
        redirect(16'h0100);
        block_prefetch = 1'b0;
        serve(16'h2211, 2);
        serve(16'h4433, 2);
        serve(16'h6655, 2);
        serve(16'h8877, 2);
        chk("full_len", ipq_len, 8);
        repeat (4) step();
        chk("full_no_req", bus.bus_req, 0);

        // One free slot at an even address is not enough for a word.
        pc = 16'h0101; #1;
        chk("len_7", ipq_len, 7);
        repeat (4) step();
        chk("free1_no_req", bus.bus_req, 0);
        pc = 16'h0102;
        serve(16'hAA99, 1);

        // Odd start: byte fetch first, then words.
        redirect(16'h0003);
        serve(16'hC3C2, 1);
        chk("odd_slot3", ipq[3], 8'hC3);
        serve(16'hD5D4, 1);
        block_prefetch = 1'b1;
        chk("odd_len", ipq_len, 3);

        // Redirect while waiting for data.
        block_prefetch = 1'b0;
        redirect(16'h0200);
        step();
        chk("wait_req", bus.bus_req, 1);
        bus.bus_ack = 1'b1; step(); bus.bus_ack = 1'b0;
        set_pc = 1'b1; new_pc = 16'h0300; pc = 16'h0300; m_ip = 16'h0300;
        step(); set_pc = 1'b0;
        step();
        chk("wait_discard_no_req", bus.bus_req, 0);
        bus.bus_rdata = 16'hBEEF; bus.bus_rvalid = 1'b1; step(); bus.bus_rvalid = 1'b0;
        chk("beef_discarded", ipq, m_pack());
        serve(16'h3130, 0);
        block_prefetch = 1'b1;

        // fetch_ip wraps FFFE -> 0000.
        block_prefetch = 1'b0;
        redirect(16'hFFFE);
        serve(16'h7776, 1);
        chk("wrap_ip_len", ipq_len, 2);
        serve(16'h0B0A, 1);
        block_prefetch = 1'b1;
        chk("wrap_len4", ipq_len, 4);

        // Clock enables gate acceptance; block does not abort an outstanding fetch.
        block_prefetch = 1'b0;
        redirect(16'h0500);
        step();
        chk("ce_req", bus.bus_req, 1);
        ce_1 = 1'b0; bus.bus_ack = 1'b1;
        step();
        chk("ce_gated_hold", bus.bus_req, 1);
        ce_2 = 1'b1;
        step();
        bus.bus_ack = 1'b0; ce_2 = 1'b0; ce_1 = 1'b1;
        chk("ce2_accept", bus.bus_req, 0);
        block_prefetch = 1'b1;
        step();
        bus.bus_rdata = 16'h5150; bus.bus_rvalid = 1'b1; step(); bus.bus_rvalid = 1'b0;
        m_q[0] = 8'h50; m_q[1] = 8'h51; m_ip = 16'h0502;
        chk("block_completes", ipq, m_pack());
        chk("block_len", ipq_len, 2);
        repeat (3) step();
        chk("block_no_req", bus.bus_req, 0);

        // Asynchronous reset in the middle of a fetch.
        block_prefetch = 1'b0;
        redirect(16'h0600);
        step();
        chk("rst_wait_req", bus.bus_req, 1);
        bus.bus_ack = 1'b1; step(); bus.bus_ack = 1'b0;
        #2; reset_n = 1'b0; pc = 16'h0000;
        #1;
        chk("arst_req", bus.bus_req, 0);
        chk("arst_addr", bus.bus_addr, 0);
        chk("arst_ipq", ipq, 0);
        chk("arst_len", ipq_len, 0);
        block_prefetch = 1'b1;
        step(); reset_n = 1'b1;
        bus.bus_rdata = 16'hFFFF; bus.bus_rvalid = 1'b1; step(); bus.bus_rvalid = 1'b0;
        chk("late_rvalid_ipq", ipq, 0);
        chk("late_rvalid_len", ipq_len, 0);
        chk("late_rvalid_req", bus.bus_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
